// File: rtl/proc_trace_pkg.sv
// proc_trace_pkg: shared capture FSM states, record layout and record width helper
package proc_trace_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  localparam int ACC_LSB = 0;
  localparam int EXT_LSB = 8;
  localparam int CB_BIT  = 16;
  localparam int TS_LSB  = 17;
  function automatic int rec_w(input int ts_w);
    return ts_w + TS_LSB;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous first-word-fall-through FIFO with occupancy counter
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = empty ? '0 : mem[rp];
  // pointers wrap naturally; count tracks push/pop independently
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage array, contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end
endmodule

// File: rtl/proc_trace_capture.sv
// proc_trace_capture: timestamps changes of ACC/EXT/CB into a FIFO with pause backpressure
module proc_trace_capture
  import proc_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W = 8,
  parameter int HI_WM = DEPTH - 2,
  parameter int LO_WM = DEPTH / 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] ACC,
  input  logic [7:0] EXT,
  input  logic CB,
  input  logic en,
  output logic pause,
  output logic rd_valid,
  input  logic rd_ready,
  output logic [TS_W+16:0] rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic overflow,
  input  logic clr_ovf
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = rec_w(TS_W);
  state_t state, nxt_state;
  logic [16:0] last, trip;
  logic [TS_W-1:0] delta, rec_ts;
  logic changed, keep, rec_v, pop, push_ok, full, empty;
  logic [CW-1:0] nxt_cnt;
  logic [RW-1:0] rec;
  assign trip = {CB, EXT, ACC};
  assign changed = trip != last;
  assign keep = (delta + 1'b1) == '1;
  assign rec = {rec_ts, trip};
  assign rd_valid = !empty;
  assign pop = rd_valid & rd_ready;
  assign push_ok = rec_v & (!full | pop);
  assign nxt_cnt = count + CW'(push_ok) - CW'(pop);
  // next state and record generation; a RUN record always carries delta+1
  always_comb begin
    nxt_state = !en ? IDLE : state == IDLE ? PRIME : RUN;
    rec_v = state == PRIME || (state == RUN && (changed || keep));
    rec_ts = state == RUN ? delta + 1'b1 : '0;
  end
  // state register, last-seen triple and delta timestamp counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= '0;
      delta <= '0;
    end else begin
      state <= nxt_state;
      if (state == PRIME || (state == RUN && changed)) last <= trip;
      if (rec_v) delta <= '0;
      else if (state == RUN) delta <= delta + 1'b1;
    end
  end
  // pause hysteresis on next occupancy; overflow is sticky with set winning over clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pause <= 1'b0;
      overflow <= 1'b0;
    end else begin
      pause <= nxt_cnt >= CW'(HI_WM) ? 1'b1 : nxt_cnt <= CW'(LO_WM) ? 1'b0 : pause;
      overflow <= (rec_v & full & !pop) | (overflow & !clr_ovf);
    end
  end
  trace_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push_ok),
    .pop(pop),
    .wdata(rec),
    .rdata(rd_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule
